// File: rtl/i2s_transmit_if.sv
// Playback-source handshake bundle for the I2S transmitter: one stereo pair per valid/ready transfer.
interface i2s_transmit_if #(
    parameter int DATA_SIZE = 24
);
    logic [DATA_SIZE-1:0] left_data;
    logic [DATA_SIZE-1:0] right_data;
    logic                 valid;
    logic                 ready;

    modport master (output left_data, output right_data, output valid, input ready);
    modport slave  (input left_data, input right_data, input valid, output ready);
endinterface

// File: rtl/i2s_transmit.sv
// I2S master transmitter: divides clk into SCK/WS and shifts stereo samples MSB-first onto SD.
// Define I2S_TX_UNDERRUN_REPEAT_EN to replay the last stereo pair on underrun instead of silence.
module i2s_transmit #(
    parameter int DATA_SIZE    = 24,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int I2S_CLK_FREQ = 1_500_000
) (
    input  logic          clk,
    input  logic          rst,
    i2s_transmit_if.slave src,
    output logic          i2s_clk,
    output logic          i2s_ws,
    output logic          i2s_sd,
    output logic          underrun
);
    localparam int CLK_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic [5:0]           bit_cnt;
    logic [5:0]           next_b;
    logic                 wrap;
    logic                 fall;
    logic                 frame_load;
    logic                 capture;
    logic                 buf_full;
    logic                 buf_full_next;
    logic                 ready_q;
    logic [DATA_SIZE-1:0] buf_left;
    logic [DATA_SIZE-1:0] buf_right;
    logic [DATA_SIZE-1:0] shift_left;
    logic [DATA_SIZE-1:0] shift_right;
    logic [DATA_SIZE-1:0] load_left;
    logic [DATA_SIZE-1:0] load_right;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [DATA_SIZE-1:0] last_left;
    logic [DATA_SIZE-1:0] last_right;
`endif

    assign src.ready  = ready_q;
    assign wrap       = (div_cnt == DIV_MAX);
    assign fall       = wrap && i2s_clk;
    assign next_b     = bit_cnt + 6'd1;
    assign frame_load = fall && (next_b == 6'd0);
    assign capture    = src.valid && ready_q;

    // A capture can only happen while the buffer is empty, so it never collides with a draining load.
    always_comb begin
        buf_full_next = buf_full;
        if (capture) begin
            buf_full_next = 1'b1;
        end else if (frame_load) begin
            buf_full_next = 1'b0;
        end
    end

    always_comb begin
        load_left  = buf_left;
        load_right = buf_right;
        if (!buf_full) begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            load_left  = last_left;
            load_right = last_right;
`else
            load_left  = '0;
            load_right = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            bit_cnt     <= 6'd63;
            i2s_clk     <= 1'b0;
            i2s_ws      <= 1'b0;
            i2s_sd      <= 1'b0;
            underrun    <= 1'b0;
            ready_q     <= 1'b1;
            buf_full    <= 1'b0;
            buf_left    <= '0;
            buf_right   <= '0;
            shift_left  <= '0;
            shift_right <= '0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last_left   <= '0;
            last_right  <= '0;
`endif
        end else begin
            underrun <= 1'b0;
            buf_full <= buf_full_next;
            ready_q  <= !buf_full_next;
            if (capture) begin
                buf_left  <= src.left_data;
                buf_right <= src.right_data;
            end
            if (wrap) begin
                div_cnt <= '0;
                i2s_clk <= ~i2s_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // WS and SD move on the SCK falling edge so the DAC sees stable data on the rising edge.
            if (fall) begin
                bit_cnt <= next_b;
                i2s_ws  <= (next_b >= 6'd31) && (next_b <= 6'd62);
                if (frame_load) begin
                    i2s_sd      <= load_left[DATA_SIZE-1];
                    shift_left  <= load_left << 1;
                    shift_right <= load_right;
                    underrun    <= !buf_full;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                    if (buf_full) begin
                        last_left  <= buf_left;
                        last_right <= buf_right;
                    end
`endif
                end else if (next_b[5]) begin
                    i2s_sd      <= shift_right[DATA_SIZE-1];
                    shift_right <= shift_right << 1;
                end else begin
                    i2s_sd     <= shift_left[DATA_SIZE-1];
                    shift_left <= shift_left << 1;
                end
            end
        end
    end
endmodule
